axi4_lite_sram: RTL and testbench
=================================

AXI4_LITE_SRAM -- requirements
Module: axi4_lite_sram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data and address width.
REQ-002 SHALL have parameter RESP_WIDTH, default 2, response width.
REQ-003 SHALL have parameter DEPTH, default 1024, number of DATA_WIDTH words (power of 2).
REQ-004 SHALL have parameter BASE, default 32'h8000_0000, byte address of word 0.
REQ-005 SHALL have parameter LATENCY, default 2, extra response delay in cycles (1..15).
REQ-006 SHALL have port iClock  in  1  single clock; all state changes on its rising edge.
REQ-007 SHALL have port iReset  in  1  asynchronous, active-high reset.
REQ-008 SHALL have read-address ports: pAXI4S_ar_valid in 1, pAXI4S_ar_bits_addr in DATA_WIDTH, pAXI4S_ar_ready out 1.
REQ-009 SHALL have read-data ports: pAXI4S_r_valid out 1, pAXI4S_r_bits_data out DATA_WIDTH, pAXI4S_r_bits_resp out RESP_WIDTH, pAXI4S_r_ready in 1.
REQ-010 SHALL have write-address ports: pAXI4S_aw_valid in 1, pAXI4S_aw_bits_addr in DATA_WIDTH, pAXI4S_aw_ready out 1.
REQ-011 SHALL have write-data ports: pAXI4S_w_valid in 1, pAXI4S_w_bits_data in DATA_WIDTH, pAXI4S_w_bits_strb in DATA_WIDTH/8, pAXI4S_w_ready out 1.
REQ-012 SHALL have write-response ports: pAXI4S_b_valid out 1, pAXI4S_b_bits_resp out RESP_WIDTH, pAXI4S_b_ready in 1.

Function
REQ-013 SHALL act as the AXI4-Lite slave memory directly consuming the AXI4-Lite master's five channels.
REQ-014 SHALL run independent read FSM (R_IDLE, R_WAIT, R_RESP) and write FSM (W_IDLE, W_WAIT, W_RESP).
REQ-015 Read: ar_ready=1 only in R_IDLE; ar handshake latches addr, goes R_WAIT; R_WAIT ends per REQ-026; enters R_RESP with r_valid=1.
REQ-016 r_valid, r_bits_data, r_bits_resp SHALL hold stable until r_ready; r handshake returns to R_IDLE, r_valid=0 next cycle.
REQ-017 Write: in W_IDLE, aw_ready=1 until aw captured and w_ready=1 until w captured; either order or same cycle; once both captured go W_WAIT.
REQ-018 Write commit SHALL occur on the W_WAIT->W_RESP edge: byte lane i written iff strb[i]=1; strb=0 writes nothing but returns OKAY.
REQ-019 b_valid, b_bits_resp SHALL hold until b_ready; b handshake returns to W_IDLE.
REQ-020 Word index = (addr-BASE)>>2; addr[1:0] ignored; addr in [BASE, BASE+4*DEPTH) gives resp OKAY (2'b00).
REQ-021 Out-of-range addr SHALL give resp SLVERR (2'b10), r_bits_data=0, no memory write.
REQ-022 Read data SHALL be sampled on the R_WAIT->R_RESP edge; if a commit to the same word occurs that edge, old data returned.
REQ-023 r_bits_data SHALL be 0 whenever r_valid=0.

Reset
REQ-024 iReset=1 SHALL immediately force both FSMs to IDLE, clear capture flags and delay counters, and drive ar_ready=1, aw_ready=1, w_ready=1, r_valid=0, b_valid=0, resp=0, r_bits_data=0.
REQ-025 Memory array SHALL not be reset; reset mid-transaction drops it with no commit unless the commit edge already passed.

Configuration
REQ-026 Macro AXI4_LITE_SRAM_DELAY_EN defined: a 4-bit counter per FSM keeps R_WAIT/W_WAIT for LATENCY+1 cycles, so valid rises LATENCY+1 cycles after the completing handshake; undefined: WAIT lasts exactly 1 cycle, counters absent, valid rises 1 cycle after the handshake.

Verification
REQ-027 Write aw=0x8000_0010, w=0xDEADBEEF, strb=4'hF, then read 0x8000_0010 -> b_resp=00, r_data=0xDEADBEEF, r_resp=00.
REQ-028 Write w before aw (3 cycles apart), strb=4'b0010, data 0x0000AB00 onto 0x11223344 -> read 0x1122AB44.
REQ-029 Read 0x8000_1000 (DEPTH=1024) and write there -> r_resp=10, r_data=0, b_resp=10, memory unchanged.
REQ-030 r_ready held 0 for 5 cycles -> r_valid/data stable, ar_ready=0 throughout; ar_ready=1 cycle after handshake.
REQ-031 With AXI4_LITE_SRAM_DELAY_EN, LATENCY=2: r_valid rises exactly 3 cycles after ar handshake; without macro: 1 cycle.
REQ-032 Assert iReset in R_WAIT and W_WAIT -> r_valid=b_valid=0, all ready=1 immediately; target word unchanged.

Source files
------------

// File: rtl/axi4_lite_sram.sv
// axi4_lite_sram: AXI4-Lite slave memory of DEPTH words starting at byte address BASE.
// The read and write channels are served by two independent FSMs. Each FSM samples or commits
// the SRAM word on its WAIT->RESP edge.
// Optional feature macro: AXI4_LITE_SRAM_DELAY_EN. When it is defined, each WAIT state lasts
// LATENCY+1 cycles. When it is undefined, each WAIT state lasts exactly one cycle.
module axi4_lite_sram #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    RESP_WIDTH = 2,
    parameter int                    DEPTH      = 1024,
    parameter logic [DATA_WIDTH-1:0] BASE       = 32'h8000_0000,
    parameter int                    LATENCY    = 2
) (
    input  logic                    iClock,
    input  logic                    iReset,
    input  logic                    pAXI4S_ar_valid,
    input  logic [DATA_WIDTH-1:0]   pAXI4S_ar_bits_addr,
    output logic                    pAXI4S_ar_ready,
    output logic                    pAXI4S_r_valid,
    output logic [DATA_WIDTH-1:0]   pAXI4S_r_bits_data,
    output logic [RESP_WIDTH-1:0]   pAXI4S_r_bits_resp,
    input  logic                    pAXI4S_r_ready,
    input  logic                    pAXI4S_aw_valid,
    input  logic [DATA_WIDTH-1:0]   pAXI4S_aw_bits_addr,
    output logic                    pAXI4S_aw_ready,
    input  logic                    pAXI4S_w_valid,
    input  logic [DATA_WIDTH-1:0]   pAXI4S_w_bits_data,
    input  logic [DATA_WIDTH/8-1:0] pAXI4S_w_bits_strb,
    output logic                    pAXI4S_w_ready,
    output logic                    pAXI4S_b_valid,
    output logic [RESP_WIDTH-1:0]   pAXI4S_b_bits_resp,
    input  logic                    pAXI4S_b_ready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int ADDR_BITS  = $clog2(DEPTH);
    localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = '0;
    localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

    // The wait counters are 4 bits wide, so only LATENCY values from 1 to 15 are meaningful.
    if (LATENCY < 1 || LATENCY > 15) begin : g_latencyCheck
        $error("axi4_lite_sram: LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} readState_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} writeState_t;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    readState_t            r_rState, w_rNext;
    logic [DATA_WIDTH-1:0] r_arAddr;
    logic [DATA_WIDTH-1:0] r_rData;
    logic [RESP_WIDTH-1:0] r_rResp;
    logic                  w_rSample;
    logic                  w_rWaitDone;

    writeState_t           r_wState, w_wNext;
    logic [DATA_WIDTH-1:0] r_awAddr;
    logic [DATA_WIDTH-1:0] r_wData;
    logic [STRB_WIDTH-1:0] r_wStrb;
    logic                  r_awDone;
    logic                  r_wDone;
    logic [RESP_WIDTH-1:0] r_bResp;
    logic                  w_commit;
    logic                  w_wWaitDone;

    // Address decode for each channel. The word offset is taken from address bit 2 upward, so
    // address bits [1:0] affect only the range check. Any offset bit at or above ADDR_BITS
    // means the address lies past the end of the array.
    logic [DATA_WIDTH-3:0] w_rWordOff, w_wWordOff;
    logic                  w_rInRange, w_wInRange;
    logic [ADDR_BITS-1:0]  w_rIdx, w_wIdx;

    assign w_rWordOff = r_arAddr[DATA_WIDTH-1:2] - BASE[DATA_WIDTH-1:2];
    assign w_wWordOff = r_awAddr[DATA_WIDTH-1:2] - BASE[DATA_WIDTH-1:2];
    assign w_rInRange = (r_arAddr >= BASE) && (w_rWordOff[DATA_WIDTH-3:ADDR_BITS] == '0);
    assign w_wInRange = (r_awAddr >= BASE) && (w_wWordOff[DATA_WIDTH-3:ADDR_BITS] == '0);
    assign w_rIdx     = w_rWordOff[ADDR_BITS-1:0];
    assign w_wIdx     = w_wWordOff[ADDR_BITS-1:0];

`ifdef AXI4_LITE_SRAM_DELAY_EN
    localparam logic [3:0] LAST_COUNT = 4'(LATENCY);

    logic [3:0] r_rCnt, r_wCnt;

    assign w_rWaitDone = (r_rCnt == LAST_COUNT);
    assign w_wWaitDone = (r_wCnt == LAST_COUNT);

    // Each counter advances only while its FSM is waiting, and returns to zero for the next wait.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_rCnt <= 4'd0;
            r_wCnt <= 4'd0;
        end else begin
            r_rCnt <= (r_rState == R_WAIT && !w_rWaitDone) ? r_rCnt + 4'd1 : 4'd0;
            r_wCnt <= (r_wState == W_WAIT && !w_wWaitDone) ? r_wCnt + 4'd1 : 4'd0;
        end
    end
`else
    assign w_rWaitDone = 1'b1;
    assign w_wWaitDone = 1'b1;
`endif

    // Read FSM state register.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) r_rState <= R_IDLE;
        else        r_rState <= w_rNext;
    end

    // Read FSM next state and handshake outputs. The memory is sampled on the WAIT->RESP edge.
    always_comb begin
        w_rNext         = r_rState;
        pAXI4S_ar_ready = 1'b0;
        pAXI4S_r_valid  = 1'b0;
        w_rSample       = 1'b0;
        unique case (r_rState)
            R_IDLE: begin
                pAXI4S_ar_ready = 1'b1;
                if (pAXI4S_ar_valid) w_rNext = R_WAIT;
            end
            R_WAIT: begin
                if (w_rWaitDone) begin
                    w_rNext   = R_RESP;
                    w_rSample = 1'b1;
                end
            end
            R_RESP: begin
                pAXI4S_r_valid = 1'b1;
                if (pAXI4S_r_ready) w_rNext = R_IDLE;
            end
            default: w_rNext = R_IDLE;
        endcase
    end

    // Read datapath. A commit to the same word on the sampling edge does not affect the value
    // read here, because this read sees the pre-edge array contents.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_arAddr <= '0;
            r_rData  <= '0;
            r_rResp  <= RESP_OKAY;
        end else begin
            if (pAXI4S_ar_ready && pAXI4S_ar_valid) r_arAddr <= pAXI4S_ar_bits_addr;
            if (w_rSample) begin
                r_rData <= w_rInRange ? r_mem[w_rIdx] : '0;
                r_rResp <= w_rInRange ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    assign pAXI4S_r_bits_data = pAXI4S_r_valid ? r_rData : '0;
    assign pAXI4S_r_bits_resp = r_rResp;

    // Write FSM state register.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) r_wState <= W_IDLE;
        else        r_wState <= w_wNext;
    end

    // Write FSM next state and outputs. The address and data beats may arrive in either order.
    // The FSM leaves IDLE once both beats have been captured or are being captured.
    always_comb begin
        w_wNext         = r_wState;
        pAXI4S_aw_ready = 1'b0;
        pAXI4S_w_ready  = 1'b0;
        pAXI4S_b_valid  = 1'b0;
        w_commit        = 1'b0;
        unique case (r_wState)
            W_IDLE: begin
                pAXI4S_aw_ready = !r_awDone;
                pAXI4S_w_ready  = !r_wDone;
                if ((r_awDone || pAXI4S_aw_valid) && (r_wDone || pAXI4S_w_valid))
                    w_wNext = W_WAIT;
            end
            W_WAIT: begin
                if (w_wWaitDone) begin
                    w_wNext  = W_RESP;
                    w_commit = 1'b1;
                end
            end
            W_RESP: begin
                pAXI4S_b_valid = 1'b1;
                if (pAXI4S_b_ready) w_wNext = W_IDLE;
            end
            default: w_wNext = W_IDLE;
        endcase
    end

    // Write capture registers and response. The capture flags clear when the FSM leaves IDLE,
    // so the next transaction starts clean.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_awAddr <= '0;
            r_wData  <= '0;
            r_wStrb  <= '0;
            r_awDone <= 1'b0;
            r_wDone  <= 1'b0;
            r_bResp  <= RESP_OKAY;
        end else begin
            if (pAXI4S_aw_ready && pAXI4S_aw_valid) begin
                r_awAddr <= pAXI4S_aw_bits_addr;
                r_awDone <= 1'b1;
            end
            if (pAXI4S_w_ready && pAXI4S_w_valid) begin
                r_wData <= pAXI4S_w_bits_data;
                r_wStrb <= pAXI4S_w_bits_strb;
                r_wDone <= 1'b1;
            end
            if (r_wState == W_IDLE && w_wNext == W_WAIT) begin
                r_awDone <= 1'b0;
                r_wDone  <= 1'b0;
            end
            if (w_commit) r_bResp <= w_wInRange ? RESP_OKAY : RESP_SLVERR;
        end
    end

    assign pAXI4S_b_bits_resp = r_bResp;

    // Byte-lane commit into the array. The array has no reset, and out-of-range writes never
    // reach it.
    always_ff @(posedge iClock) begin
        if (w_commit && w_wInRange) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (r_wStrb[i]) r_mem[w_wIdx][i*8 +: 8] <= r_wData[i*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_sram.sv
// tb_axi4_lite_sram: self-checking bench for axi4_lite_sram.
// The bench applies a table of directed vectors, then several hand-written corner sequences,
// then randomized traffic that is checked against a word-array reference model.
module tb_axi4_lite_sram;

    localparam int          DW      = 32;
    localparam int          DEPTH   = 1024;
    localparam int          LATENCY = 2;
    localparam logic [31:0] BASE    = 32'h8000_0000;
`ifdef AXI4_LITE_SRAM_DELAY_EN
    localparam int EXP_LAT = LATENCY + 1;
`else
    localparam int EXP_LAT = 1;
`endif

    logic          iClock, iReset;
    logic          pAXI4S_ar_valid, pAXI4S_ar_ready;
    logic [DW-1:0] pAXI4S_ar_bits_addr;
    logic          pAXI4S_r_valid, pAXI4S_r_ready;
    logic [DW-1:0] pAXI4S_r_bits_data;
    logic [1:0]    pAXI4S_r_bits_resp;
    logic          pAXI4S_aw_valid, pAXI4S_aw_ready;
    logic [DW-1:0] pAXI4S_aw_bits_addr;
    logic          pAXI4S_w_valid, pAXI4S_w_ready;
    logic [DW-1:0] pAXI4S_w_bits_data;
    logic [3:0]    pAXI4S_w_bits_strb;
    logic          pAXI4S_b_valid, pAXI4S_b_ready;
    logic [1:0]    pAXI4S_b_bits_resp;

    axi4_lite_sram #(
        .DATA_WIDTH(DW), .RESP_WIDTH(2), .DEPTH(DEPTH), .BASE(BASE), .LATENCY(LATENCY)
    ) dut (
        .iClock(iClock), .iReset(iReset),
        .pAXI4S_ar_valid(pAXI4S_ar_valid), .pAXI4S_ar_bits_addr(pAXI4S_ar_bits_addr),
        .pAXI4S_ar_ready(pAXI4S_ar_ready),
        .pAXI4S_r_valid(pAXI4S_r_valid), .pAXI4S_r_bits_data(pAXI4S_r_bits_data),
        .pAXI4S_r_bits_resp(pAXI4S_r_bits_resp), .pAXI4S_r_ready(pAXI4S_r_ready),
        .pAXI4S_aw_valid(pAXI4S_aw_valid), .pAXI4S_aw_bits_addr(pAXI4S_aw_bits_addr),
        .pAXI4S_aw_ready(pAXI4S_aw_ready),
        .pAXI4S_w_valid(pAXI4S_w_valid), .pAXI4S_w_bits_data(pAXI4S_w_bits_data),
        .pAXI4S_w_bits_strb(pAXI4S_w_bits_strb), .pAXI4S_w_ready(pAXI4S_w_ready),
        .pAXI4S_b_valid(pAXI4S_b_valid), .pAXI4S_b_bits_resp(pAXI4S_b_bits_resp),
        .pAXI4S_b_ready(pAXI4S_b_ready)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        iClock = 1'b0;
        forever #5 iClock = ~iClock;
    end

    int total = 0;
    int bad   = 0;

    // Reference memory: word index -> contents. Only words the bench has written are present.
    logic [31:0] model [int];

    typedef struct {
        bit          isRead;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          order;
        int          gap;
        int          hold;
        logic [31:0] expData;
        logic [1:0]  expResp;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit modelInRange(input logic [31:0] a);
        longint unsigned x;
        x = 64'(a);
        return (x >= 64'(BASE)) && (x < 64'(BASE) + 64'(4 * DEPTH));
    endfunction

    function automatic int modelIdx(input logic [31:0] a);
        longint unsigned x;
        x = (64'(a) - 64'(BASE)) / 4;
        return int'(x);
    endfunction

    task automatic modelWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        if (modelInRange(a)) begin
            w = model.exists(modelIdx(a)) ? model[modelIdx(a)] : 32'h0;
            for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
            model[modelIdx(a)] = w;
        end
    endtask

    // Writes one word. order 0 presents aw and w together. order 1 presents aw first and w
    // gap cycles later. order 2 presents w first and aw gap cycles later.
    task automatic doWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int order, input int gap, output logic [1:0] resp, output int lat);
        bit awDone = 0;
        bit wDone  = 0;
        int c      = 0;
        int awStart = (order == 2) ? gap : 0;
        int wStart  = (order == 1) ? gap : 0;
        pAXI4S_b_ready = 1'b1;
        while (!(awDone && wDone) && c < 100) begin
            @(negedge iClock);
            pAXI4S_aw_bits_addr = addr;
            pAXI4S_w_bits_data  = data;
            pAXI4S_w_bits_strb  = strb;
            pAXI4S_aw_valid     = !awDone && (c >= awStart);
            pAXI4S_w_valid      = !wDone && (c >= wStart);
            if (pAXI4S_aw_valid && pAXI4S_aw_ready) awDone = 1;
            if (pAXI4S_w_valid && pAXI4S_w_ready) wDone = 1;
            c++;
        end
        if (!(awDone && wDone)) checkOutput("wr_handshake_timeout", 32'(c), 32'(0));
        lat = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge iClock);
            pAXI4S_aw_valid = 1'b0;
            pAXI4S_w_valid  = 1'b0;
            if (pAXI4S_b_valid) break;
            lat++;
        end
        resp = pAXI4S_b_bits_resp;
        @(negedge iClock);
        pAXI4S_b_ready = 1'b0;
        checkOutput("b_valid_drop", 32'(pAXI4S_b_valid), 32'(0));
        checkOutput("aw_ready_back", 32'(pAXI4S_aw_ready), 32'(1));
    endtask

    // Reads one word. r_ready is held low for hold cycles after r_valid rises, and the response
    // is checked for stability during that stall.
    task automatic doRead(input logic [31:0] addr, input int hold,
                          output logic [31:0] data, output logic [1:0] resp, output int lat);
        bit done = 0;
        int c    = 0;
        pAXI4S_r_ready = 1'b0;
        while (!done && c < 100) begin
            @(negedge iClock);
            pAXI4S_ar_valid     = 1'b1;
            pAXI4S_ar_bits_addr = addr;
            if (pAXI4S_ar_ready) done = 1;
            c++;
        end
        if (!done) checkOutput("ar_handshake_timeout", 32'(c), 32'(0));
        lat = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge iClock);
            pAXI4S_ar_valid = 1'b0;
            if (pAXI4S_r_valid) break;
            lat++;
        end
        data = pAXI4S_r_bits_data;
        resp = pAXI4S_r_bits_resp;
        for (int k = 0; k < hold; k++) begin
            @(negedge iClock);
            checkOutput("r_valid_hold", 32'(pAXI4S_r_valid), 32'(1));
            checkOutput("r_data_hold", pAXI4S_r_bits_data, data);
            checkOutput("ar_ready_busy", 32'(pAXI4S_ar_ready), 32'(0));
        end
        pAXI4S_r_ready = 1'b1;
        @(negedge iClock);
        pAXI4S_r_ready = 1'b0;
        checkOutput("r_valid_drop", 32'(pAXI4S_r_valid), 32'(0));
        checkOutput("r_data_idle_zero", pAXI4S_r_bits_data, 32'h0);
        checkOutput("ar_ready_back", 32'(pAXI4S_ar_ready), 32'(1));
    endtask

    task automatic addVec(input bit isRead, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int order, input int gap, input int hold,
                          input logic [31:0] expData, input logic [1:0] expResp);
        vec_t v;
        v.isRead = isRead; v.addr = addr; v.data = data; v.strb = strb;
        v.order = order; v.gap = gap; v.hold = hold; v.expData = expData; v.expResp = expResp;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        if (v.isRead) begin
            doRead(v.addr, v.hold, d, r, lat);
            checkOutput("vec_r_data", d, v.expData);
            checkOutput("vec_r_resp", 32'(r), 32'(v.expResp));
            checkOutput("vec_r_latency", 32'(lat), 32'(EXP_LAT));
        end else begin
            doWrite(v.addr, v.data, v.strb, v.order, v.gap, r, lat);
            checkOutput("vec_b_resp", 32'(r), 32'(v.expResp));
            checkOutput("vec_b_latency", 32'(lat), 32'(EXP_LAT));
        end
    endtask

    // Main test sequence.
    initial begin
        logic [31:0] d, a, rdata;
        logic [1:0]  r;
        int          lat;
        bit          rGot, bGot;

        iReset = 1'b1;
        pAXI4S_ar_valid = 0; pAXI4S_ar_bits_addr = 0; pAXI4S_r_ready = 0;
        pAXI4S_aw_valid = 0; pAXI4S_aw_bits_addr = 0;
        pAXI4S_w_valid = 0; pAXI4S_w_bits_data = 0; pAXI4S_w_bits_strb = 0;
        pAXI4S_b_ready = 0;

        repeat (2) @(negedge iClock);
        checkOutput("rst_ar_ready", 32'(pAXI4S_ar_ready), 32'(1));
        checkOutput("rst_aw_ready", 32'(pAXI4S_aw_ready), 32'(1));
        checkOutput("rst_w_ready", 32'(pAXI4S_w_ready), 32'(1));
        checkOutput("rst_r_valid", 32'(pAXI4S_r_valid), 32'(0));
        checkOutput("rst_b_valid", 32'(pAXI4S_b_valid), 32'(0));
        checkOutput("rst_r_data", pAXI4S_r_bits_data, 32'h0);
        checkOutput("rst_r_resp", 32'(pAXI4S_r_bits_resp), 32'(0));
        checkOutput("rst_b_resp", 32'(pAXI4S_b_bits_resp), 32'(0));
        iReset = 1'b0;

        //      rd addr           data           strb  ord gap hold expData        resp
        addVec(0, 32'h8000_0010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 32'h0,         2'b00);
        addVec(1, 32'h8000_0010, 32'h0,        4'h0, 0, 0, 0, 32'hDEADBEEF,  2'b00);
        addVec(0, 32'h8000_0020, 32'h11223344, 4'hF, 0, 0, 0, 32'h0,         2'b00);
        addVec(0, 32'h8000_0020, 32'h0000AB00, 4'h2, 2, 3, 0, 32'h0,         2'b00);
        addVec(1, 32'h8000_0020, 32'h0,        4'h0, 0, 0, 5, 32'h1122AB44,  2'b00);
        addVec(0, 32'h8000_0000, 32'hCAFEF00D, 4'hF, 1, 2, 0, 32'h0,         2'b00);
        addVec(1, 32'h8000_1000, 32'h0,        4'h0, 0, 0, 0, 32'h0,         2'b10);
        addVec(0, 32'h8000_1000, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 32'h0,         2'b10);
        addVec(1, 32'h8000_0000, 32'h0,        4'h0, 0, 0, 0, 32'hCAFEF00D,  2'b00);
        addVec(0, 32'h8000_0FFC, 32'h0A0B0C0D, 4'hF, 1, 1, 0, 32'h0,         2'b00);
        addVec(1, 32'h8000_0FFE, 32'h0,        4'h0, 0, 0, 1, 32'h0A0B0C0D,  2'b00);
        addVec(1, 32'h7FFF_FFFC, 32'h0,        4'h0, 0, 0, 0, 32'h0,         2'b10);
        addVec(0, 32'h8000_0013, 32'hFFFFFFFF, 4'h0, 0, 0, 0, 32'h0,         2'b00);
        addVec(1, 32'h8000_0010, 32'h0,        4'h0, 0, 0, 0, 32'hDEADBEEF,  2'b00);
        addVec(0, 32'h8000_0010, 32'h11000000, 4'h8, 2, 1, 0, 32'h0,         2'b00);
        addVec(1, 32'h8000_0011, 32'h0,        4'h0, 0, 0, 0, 32'h11ADBEEF,  2'b00);
        addVec(0, 32'h7FFF_FFF0, 32'h01234567, 4'hF, 0, 0, 0, 32'h0,         2'b10);
        addVec(1, 32'hFFFF_FFFC, 32'h0,        4'h0, 0, 0, 0, 32'h0,         2'b10);

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // A read and a write to the same word start together, so the read must return the old value.
        doWrite(32'h8000_0050, 32'h0BADF00D, 4'hF, 0, 0, r, lat);
        @(negedge iClock);
        pAXI4S_ar_valid = 1; pAXI4S_ar_bits_addr = 32'h8000_0050;
        pAXI4S_aw_valid = 1; pAXI4S_aw_bits_addr = 32'h8000_0050;
        pAXI4S_w_valid = 1; pAXI4S_w_bits_data = 32'h55555555; pAXI4S_w_bits_strb = 4'hF;
        pAXI4S_r_ready = 1; pAXI4S_b_ready = 1;
        rGot = 0; bGot = 0; rdata = 32'h0;
        for (int k = 0; k < 40 && !(rGot && bGot); k++) begin
            @(negedge iClock);
            pAXI4S_ar_valid = 0; pAXI4S_aw_valid = 0; pAXI4S_w_valid = 0;
            if (pAXI4S_r_valid && !rGot) begin rGot = 1; rdata = pAXI4S_r_bits_data; end
            if (pAXI4S_b_valid) bGot = 1;
        end
        @(negedge iClock);
        pAXI4S_r_ready = 0; pAXI4S_b_ready = 0;
        checkOutput("same_edge_rw_seen", 32'({rGot, bGot}), 32'h3);
        checkOutput("same_edge_old_data", rdata, 32'h0BADF00D);
        doRead(32'h8000_0050, 0, d, r, lat);
        checkOutput("same_edge_new_data", d, 32'h55555555);

        // Reset while the read FSM is in its WAIT state.
        @(negedge iClock);
        pAXI4S_ar_valid = 1; pAXI4S_ar_bits_addr = 32'h8000_0010;
        @(negedge iClock);
        pAXI4S_ar_valid = 0;
        iReset = 1;
        #1;
        checkOutput("rstR_r_valid", 32'(pAXI4S_r_valid), 32'(0));
        checkOutput("rstR_ar_ready", 32'(pAXI4S_ar_ready), 32'(1));
        checkOutput("rstR_aw_ready", 32'(pAXI4S_aw_ready), 32'(1));
        checkOutput("rstR_w_ready", 32'(pAXI4S_w_ready), 32'(1));
        checkOutput("rstR_r_data", pAXI4S_r_bits_data, 32'h0);
        @(negedge iClock);
        iReset = 0;

        // Reset while the write FSM is in its WAIT state. The target word must keep its old value.
        doWrite(32'h8000_0040, 32'h12345678, 4'hF, 0, 0, r, lat);
        @(negedge iClock);
        pAXI4S_aw_valid = 1; pAXI4S_aw_bits_addr = 32'h8000_0040;
        pAXI4S_w_valid = 1; pAXI4S_w_bits_data = 32'h87654321; pAXI4S_w_bits_strb = 4'hF;
        @(negedge iClock);
        pAXI4S_aw_valid = 0; pAXI4S_w_valid = 0;
        iReset = 1;
        #1;
        checkOutput("rstW_b_valid", 32'(pAXI4S_b_valid), 32'(0));
        checkOutput("rstW_r_valid", 32'(pAXI4S_r_valid), 32'(0));
        checkOutput("rstW_aw_ready", 32'(pAXI4S_aw_ready), 32'(1));
        checkOutput("rstW_w_ready", 32'(pAXI4S_w_ready), 32'(1));
        checkOutput("rstW_ar_ready", 32'(pAXI4S_ar_ready), 32'(1));
        @(negedge iClock);
        iReset = 0;
        doRead(32'h8000_0040, 0, d, r, lat);
        checkOutput("rstW_word_kept", d, 32'h12345678);

        // Randomized traffic over a small pool of words, plus occasional out-of-range addresses.
        for (int i = 0; i < 8; i++) begin
            a = 32'h8000_0100 + 32'(4 * i);
            d = $urandom;
            doWrite(a, d, 4'hF, 0, 0, r, lat);
            modelWrite(a, d, 4'hF);
            checkOutput("rnd_init_b_resp", 32'(r), 32'(0));
        end
        for (int i = 0; i < 60; i++) begin
            logic [31:0] expD;
            logic [1:0]  expR;
            if ($urandom_range(0, 7) == 0) begin
                a = ($urandom_range(0, 1) == 0) ? BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 15))
                                                : BASE - 32'(4 * $urandom_range(1, 16));
            end else begin
                a = 32'h8000_0100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            end
            expR = modelInRange(a) ? 2'b00 : 2'b10;
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom;
                doWrite(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 3),
                        r, lat);
                modelWrite(a, d, pAXI4S_w_bits_strb);
                checkOutput("rnd_b_resp", 32'(r), 32'(expR));
                checkOutput("rnd_b_latency", 32'(lat), 32'(EXP_LAT));
            end else begin
                expD = modelInRange(a) ? model[modelIdx(a)] : 32'h0;
                doRead(a, $urandom_range(0, 2), d, r, lat);
                checkOutput("rnd_r_data", d, expD);
                checkOutput("rnd_r_resp", 32'(r), 32'(expR));
                checkOutput("rnd_r_latency", 32'(lat), 32'(EXP_LAT));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
